// File: rtl/serial_adder_pkg.sv
// Shared constants, state encoding and helpers for the bit-serial adder controller.
package serial_adder_pkg;

    // Raw state codes; the spare fourth code is treated as idle.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StRun   = ST_RUN,
        StDone  = ST_DONE,
        StSpare = 2'd3
    } state_e;

    // Bit-counter width: clog2 of the operand width, never less than one bit.
    function automatic int unsigned sa_cnt_width(input int unsigned w);
        int unsigned r;
        r = (w > 1) ? $clog2(w) : 1;
        return r;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder used as the serial datapath cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and majority carry.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds WIDTH-bit operands LSB first through one full-adder cell,
// one bit per clock, with a start/busy/done handshake.
// Optional feature macro SERIAL_ADD_OVF_EN adds the signed-overflow output Ovf.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned    CntW    = sa_cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] sha_q, shb_q, shs_q, shs_next;
    logic [WIDTH-1:0] sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q, cout_q;
    logic             fa_s, fa_c;
    logic             load, step, last;

    fa_cell u_fa (
        .a  (sha_q[0]),
        .b  (shb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH steps the LSB has reached bit 0.
    if (WIDTH == 1) begin : g_shs_w1
        assign shs_next = fa_s;
    end else begin : g_shs_wn
        assign shs_next = {fa_s, shs_q[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            StRun: begin
                step = 1'b1;
                if (cnt_q == CntLast) begin
                    last    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StIdle, StSpare: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
        endcase
        busy = (state_q == StRun) || (state_q == StDone);
        done = (state_q == StDone);
    end

    // Operand shift registers, carry, bit counter and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sha_q   <= '0;
            shb_q   <= '0;
            shs_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (load) begin
            sha_q   <= A;
            shb_q   <= B;
            carry_q <= Cin;
            cnt_q   <= '0;
            shs_q   <= '0;
        end else if (step) begin
            shs_q   <= shs_next;
            sha_q   <= sha_q >> 1;
            shb_q   <= shb_q >> 1;
            carry_q <= fa_c;
            cnt_q   <= cnt_q + CntW'(1);
            if (last) begin
                sum_q  <= shs_next;
                cout_q <= fa_c;
            end
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // Overflow: carry into the MSB (carry FF on the last step) differs from carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= carry_q ^ fa_c;
        end
    end

    assign Ovf = ovf_q;
`endif

endmodule
